// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ALU ops, forward selects,
// writeback sources, branch conditions and the EX/MEM bundle.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  result_src;
    logic        regwrite_en;
    logic        memwrite_en;
    logic        misalign;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// RV32I combinational ALU; unknown op codes yield zero.
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] y
);

  logic [4:0] sh;
  assign sh = b[4:0];

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLT:   y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {31'd0, a < b};
      ALU_SLL:   y = a << sh;
      ALU_SRL:   y = a >> sh;
      ALU_SRA:   y = $unsigned($signed(a) >>> sh);
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage with EX/MEM register.
// Optional EXEC_MISALIGN_TRAP_EN traps redirects with target bit1 set.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_m,
  input  logic            flush_e,
  input  logic [XLEN-1:0] id_ex_pc,
  input  logic [XLEN-1:0] id_ex_pc_plus4,
  input  logic [XLEN-1:0] id_ex_rd1,
  input  logic [XLEN-1:0] id_ex_rd2,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic [4:0]      id_ex_rd,
  input  logic [3:0]      id_ex_alu_ctrl,
  input  logic [2:0]      id_ex_funct3,
  input  logic            id_ex_alu_src,
  input  logic            id_ex_op_a_pc,
  input  logic            id_ex_regwrite_en,
  input  logic            id_ex_memwrite_en,
  input  logic            id_ex_branch,
  input  logic            id_ex_jump,
  input  logic            id_ex_jalr,
  input  logic [1:0]      id_ex_result_src,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] mem_wb_result,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_write_data,
  output logic [XLEN-1:0] ex_mem_pc_plus4,
  output logic [4:0]      ex_mem_rd,
  output logic [2:0]      ex_mem_funct3,
  output logic [1:0]      ex_mem_result_src,
`ifdef EXEC_MISALIGN_TRAP_EN
  output logic            ex_mem_misalign,
`endif
  output logic            ex_mem_regwrite_en,
  output logic            ex_mem_memwrite_en
);

  ex_mem_t q, d;
  logic [31:0] fwd_a, fwd_b, src_a, src_b, alu_y;
  logic [31:0] tgt_sum;
  logic        taken, redirect, misalign;

  always_comb begin
    fwd_a = id_ex_rd1;
    case (forwardAE)
      FWD_WB:  fwd_a = mem_wb_result;
      FWD_MEM: fwd_a = q.alu_result;
      default: fwd_a = id_ex_rd1;
    endcase
  end

  always_comb begin
    fwd_b = id_ex_rd2;
    case (forwardBE)
      FWD_WB:  fwd_b = mem_wb_result;
      FWD_MEM: fwd_b = q.alu_result;
      default: fwd_b = id_ex_rd2;
    endcase
  end

  assign src_a = id_ex_op_a_pc ? id_ex_pc : fwd_a;
  assign src_b = id_ex_alu_src ? id_ex_imm : fwd_b;

  alu u_alu (
    .a    (src_a),
    .b    (src_b),
    .ctrl (id_ex_alu_ctrl),
    .y    (alu_y)
  );

  always_comb begin
    taken = 1'b0;
    case (id_ex_funct3)
      F3_BEQ:  taken = fwd_a == fwd_b;
      F3_BNE:  taken = fwd_a != fwd_b;
      F3_BLT:  taken = $signed(fwd_a) < $signed(fwd_b);
      F3_BGE:  taken = $signed(fwd_a) >= $signed(fwd_b);
      F3_BLTU: taken = fwd_a < fwd_b;
      F3_BGEU: taken = fwd_a >= fwd_b;
      default: taken = 1'b0;
    endcase
  end

  assign tgt_sum = (id_ex_jalr ? fwd_a : id_ex_pc) + id_ex_imm;
  assign pc_target_e = id_ex_jalr ? {tgt_sum[31:1], 1'b0}
                                  : tgt_sum;
  assign redirect = id_ex_jump | (id_ex_branch & taken);

`ifdef EXEC_MISALIGN_TRAP_EN
  assign misalign = redirect & pc_target_e[1];
`else
  assign misalign = 1'b0;
`endif

  assign pc_src_e = redirect & ~misalign;

  always_comb begin
    d.alu_result  = alu_y;
    d.write_data  = fwd_b;
    d.pc_plus4    = id_ex_pc_plus4;
    d.rd          = id_ex_rd;
    d.funct3      = id_ex_funct3;
    d.result_src  = id_ex_result_src;
    d.regwrite_en = id_ex_regwrite_en & ~misalign;
    d.memwrite_en = id_ex_memwrite_en & ~misalign;
    d.misalign    = misalign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q <= '0;
    else if (flush_e) q <= '0;
    else if (!stall_m) q <= d;
  end

  assign ex_mem_alu_result  = q.alu_result;
  assign ex_mem_write_data  = q.write_data;
  assign ex_mem_pc_plus4    = q.pc_plus4;
  assign ex_mem_rd          = q.rd;
  assign ex_mem_funct3      = q.funct3;
  assign ex_mem_result_src  = q.result_src;
  assign ex_mem_regwrite_en = q.regwrite_en;
  assign ex_mem_memwrite_en = q.memwrite_en;
`ifdef EXEC_MISALIGN_TRAP_EN
  assign ex_mem_misalign    = q.misalign;
`else
  logic unused_misalign;
  assign unused_misalign = q.misalign;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed vector bench for execute_stage.
module tb_execute_stage;

  logic        clk = 0, rst = 1, stall_m = 0, flush_e = 0;
  logic [31:0] pc, pc4, rd1, rd2, imm, mwb;
  logic [4:0]  rd;
  logic [3:0]  ctrl;
  logic [2:0]  f3;
  logic        asrc, apc, rw, mw, br, jmp, jalr;
  logic [1:0]  rsrc, fa, fb;
  logic        pc_src;
  logic [31:0] tgt, q_res, q_wd, q_pc4;
  logic [4:0]  q_rd;
  logic [2:0]  q_f3;
  logic [1:0]  q_rsrc;
  logic        q_rw, q_mw;
`ifdef EXEC_MISALIGN_TRAP_EN
  logic        q_mis;
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst), .stall_m(stall_m), .flush_e(flush_e),
    .id_ex_pc(pc), .id_ex_pc_plus4(pc4),
    .id_ex_rd1(rd1), .id_ex_rd2(rd2), .id_ex_imm(imm),
    .id_ex_rd(rd), .id_ex_alu_ctrl(ctrl), .id_ex_funct3(f3),
    .id_ex_alu_src(asrc), .id_ex_op_a_pc(apc),
    .id_ex_regwrite_en(rw), .id_ex_memwrite_en(mw),
    .id_ex_branch(br), .id_ex_jump(jmp), .id_ex_jalr(jalr),
    .id_ex_result_src(rsrc), .forwardAE(fa), .forwardBE(fb),
    .mem_wb_result(mwb), .pc_src_e(pc_src), .pc_target_e(tgt),
    .ex_mem_alu_result(q_res), .ex_mem_write_data(q_wd),
    .ex_mem_pc_plus4(q_pc4), .ex_mem_rd(q_rd),
    .ex_mem_funct3(q_f3), .ex_mem_result_src(q_rsrc),
`ifdef EXEC_MISALIGN_TRAP_EN
    .ex_mem_misalign(q_mis),
`endif
    .ex_mem_regwrite_en(q_rw), .ex_mem_memwrite_en(q_mw)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [2:0]  f3;
    logic [31:0] pc, rd1, rd2, imm;
    logic        asrc, apc, br, jmp, jalr;
    logic        e_src;
    logic [31:0] e_tgt, e_res;
    logic        e_rw;
  } vec_t;

  vec_t v[13];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle();
    pc = 0; pc4 = 0; rd1 = 0; rd2 = 0; imm = 0; mwb = 0; rd = 0;
    ctrl = 0; f3 = 3'b010; asrc = 0; apc = 0; rw = 0; mw = 0;
    br = 0; jmp = 0; jalr = 0; rsrc = 0; fa = 0; fb = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(string n);
    chk({n, ".res"}, q_res, 0);
    chk({n, ".wd"}, q_wd, 0);
    chk({n, ".pc4"}, q_pc4, 0);
    chk({n, ".ctl"}, {20'd0, q_rd, q_f3, q_rsrc, q_rw, q_mw}, 0);
  endtask

  initial begin
    v[0]  = '{"add",  4'b0000, 3'b010, 0, 5, 7, 0,
              0, 0, 0, 0, 0, 0, 32'h0, 12, 1};
    v[1]  = '{"sub",  4'b0001, 3'b010, 0, 0, 1, 0,
              0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 1};
    v[2]  = '{"sra",  4'b1001, 3'b010, 0, 32'h80000000, 31, 0,
              0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 1};
    v[3]  = '{"sll",  4'b0111, 3'b010, 0, 1, 32'h21, 0,
              0, 0, 0, 0, 0, 0, 32'h0, 2, 1};
    v[4]  = '{"bad",  4'b1111, 3'b010, 0, 9, 3, 0,
              0, 0, 0, 0, 0, 0, 32'h0, 0, 1};
    v[5]  = '{"slt",  4'b0101, 3'b010, 0, 32'hFFFFFFFF, 1, 0,
              0, 0, 0, 0, 0, 0, 32'h0, 1, 1};
    v[6]  = '{"sltu", 4'b0110, 3'b010, 0, 32'hFFFFFFFF, 1, 0,
              0, 0, 0, 0, 0, 0, 32'h0, 0, 1};
    v[7]  = '{"lui",  4'b1010, 3'b010, 0, 9, 3, 32'h12345000,
              1, 0, 0, 0, 0, 0, 32'h12345000, 32'h12345000, 1};
    v[8]  = '{"auipc", 4'b0000, 3'b010, 32'h100, 9, 3, 32'h1000,
              1, 1, 0, 0, 0, 0, 32'h1100, 32'h1100, 1};
    v[9]  = '{"blt",  4'b0001, 3'b100, 32'h100, 32'hFFFFFFFF, 1,
              32'h40, 0, 0, 1, 0, 0, 1, 32'h140, 32'hFFFFFFFE, 1};
    v[10] = '{"bltu", 4'b0001, 3'b110, 32'h100, 32'hFFFFFFFF, 1,
              32'h40, 0, 0, 1, 0, 0, 0, 32'h140, 32'hFFFFFFFE, 1};
    v[11] = '{"jalr", 4'b0000, 3'b000, 32'h50, 32'h203, 0, 0,
              1, 0, 0, 1, 1, !MIS, 32'h202, 32'h203, !MIS};
    v[12] = '{"beq",  4'b0001, 3'b000, 32'h0, 3, 3, 8,
              0, 0, 1, 0, 0, 1, 32'h8, 0, 1};

    idle();
    #12;
    rst = 0;
    step();

    // Reset mid-run: load something, then assert rst asynchronously
    rd1 = 32'h55; rd2 = 1; rd = 7; rw = 1; pc4 = 32'h44;
    step();
    chk("pre_rst", q_res, 32'h56);
    #2 rst = 1; #1;
    chk_zero("rst");
    step();
    rst = 0;
    idle();
    rd1 = 5; rd2 = 7; rd = 3; rw = 1; ctrl = 4'b0000;
    pc4 = 32'h104; rsrc = 2'b10; f3 = 3'b011;
    step();
    chk("rst_add.res", q_res, 12);
    chk("rst_add.rd", {27'd0, q_rd}, 3);
    chk("rst_add.pc4", q_pc4, 32'h104);
    chk("rst_add.pt", {27'd0, q_f3, q_rsrc}, {27'd0, 3'b011, 2'b10});

    for (int i = 0; i < 13; i++) begin
      idle();
      ctrl = v[i].ctrl; f3 = v[i].f3; pc = v[i].pc;
      rd1 = v[i].rd1; rd2 = v[i].rd2; imm = v[i].imm;
      asrc = v[i].asrc; apc = v[i].apc; br = v[i].br;
      jmp = v[i].jmp; jalr = v[i].jalr; rw = 1; rd = 5'd1;
      #1;
      chk({v[i].name, ".src"}, {31'd0, pc_src}, {31'd0, v[i].e_src});
      chk({v[i].name, ".tgt"}, tgt, v[i].e_tgt);
      step();
      chk({v[i].name, ".res"}, q_res, v[i].e_res);
      chk({v[i].name, ".wd"}, q_wd, v[i].rd2);
      chk({v[i].name, ".rw"}, {31'd0, q_rw}, {31'd0, v[i].e_rw});
`ifdef EXEC_MISALIGN_TRAP_EN
      chk({v[i].name, ".mis"}, {31'd0, q_mis},
          {31'd0, v[i].jalr});
`endif
    end

    // Forwarding from EX/MEM and WB
    idle();
    rd1 = 32'h10; rw = 1; rd = 4;
    step();
    chk("fwd_setup", q_res, 32'h10);
    idle();
    mwb = 32'h20; fa = 2'b10; fb = 2'b01; rw = 1; rd = 5;
    rd1 = 32'hDEAD; rd2 = 32'hBEEF;
    step();
    chk("fwd_mem_wb", q_res, 32'h30);
    chk("fwd_wd", q_wd, 32'h20);
    fa = 2'b11; rd1 = 32'h100;
    step();
    chk("fwd_rsvd", q_res, 32'h120);

    // Stall holds, flush beats stall
    stall_m = 1; rd1 = 32'h999; rd = 9; mw = 1; pc4 = 32'h77;
    step();
    chk("stall1.res", q_res, 32'h120);
    step();
    chk("stall2.res", q_res, 32'h120);
    chk("stall2.ctl", {25'd0, q_rd, q_rw, q_mw}, {25'd0, 5'd5, 2'b10});
    chk("stall2.pc4", q_pc4, 0);
    flush_e = 1;
    step();
    chk_zero("flush");
    stall_m = 0; flush_e = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
